// File: rtl/alu_writeback_pkg.sv
// Shared ALU/writeback definitions: op codes, destinations,
// status-register bit positions and the reset value of P.
package alu_writeback_pkg;

    typedef enum logic [4:0] {
        OP_ADD = 5'd0,
        OP_SUB = 5'd1,
        OP_AND = 5'd2,
        OP_OR  = 5'd3,
        OP_XOR = 5'd4,
        OP_INC = 5'd5,
        OP_DEC = 5'd6,
        OP_SHL = 5'd7,
        OP_SHR = 5'd8,
        OP_ROL = 5'd9,
        OP_ROR = 5'd10,
        OP_CMP = 5'd11,
        OP_LD  = 5'd12
    } alu_op_e;

    typedef enum logic [1:0] {
        DEST_A = 2'd0,
        DEST_X = 2'd1,
        DEST_Y = 2'd2,
        DEST_M = 2'd3
    } dest_e;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_MEMWR
    } wb_state_e;

    // P bit order: N V 1 B D I Z C
    localparam int FLAG_C   = 0;
    localparam int FLAG_Z   = 1;
    localparam int FLAG_I   = 2;
    localparam int FLAG_D   = 3;
    localparam int FLAG_B   = 4;
    localparam int FLAG_ONE = 5;
    localparam int FLAG_V   = 6;
    localparam int FLAG_N   = 7;

    // issue_mask bit order: {N,V,Z,C}
    localparam int MASK_C = 0;
    localparam int MASK_Z = 1;
    localparam int MASK_V = 2;
    localparam int MASK_N = 3;

    localparam logic [7:0] P_RESET_DEF = 8'h34;
    localparam logic [7:0] P_ONE_BIT   = 8'h20;

    function automatic logic [7:0] p_fix(input logic [7:0] p);
        return p | P_ONE_BIT;
    endfunction

endpackage

// File: rtl/alu_writeback_if.sv
// Memory write request channel from writeback to the bus.
// Request and data hold until the bus acknowledges.
interface alu_writeback_if;
    logic       mem_wr_req;
    logic [7:0] mem_wr_data;
    logic       mem_wr_ack;

    modport master (
        output mem_wr_req,
        output mem_wr_data,
        input  mem_wr_ack
    );

    modport slave (
        input  mem_wr_req,
        input  mem_wr_data,
        output mem_wr_ack
    );
endinterface

// File: rtl/alu_writeback_status_merge.sv
// Status register next-value: whole-register load first,
// then masked ALU flags override it.
module status_merge
    import alu_writeback_pkg::*;
(
    input  logic [7:0] p_old,
    input  logic [7:0] result,
    input  logic       carry,
    input  logic       overflow,
    input  logic [3:0] mask,
    input  logic       p_load,
    input  logic [7:0] p_load_data,
    output logic [7:0] p_new
);

    always_comb begin
        p_new = p_load ? p_load_data : p_old;
        if (mask[MASK_N]) p_new[FLAG_N] = result[7];
        if (mask[MASK_V]) p_new[FLAG_V] = overflow;
        if (mask[MASK_Z]) p_new[FLAG_Z] = (result == 8'h00);
        if (mask[MASK_C]) p_new[FLAG_C] = carry;
        p_new = p_fix(p_new);
    end

endmodule

// File: rtl/alu_writeback.sv
// ALU writeback: latches an issued op, commits the ALU result
// to A/X/Y or a memory write, and merges flags into P.
module alu_writeback
    import alu_writeback_pkg::*;
#(
    parameter logic [7:0] P_RESET  = P_RESET_DEF,
    parameter logic [1:0] DEST_MEM = 2'd3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             issue,
    input  logic [4:0]       issue_op,
    input  logic [1:0]       issue_dest,
    input  logic [3:0]       issue_mask,
    input  logic [7:0]       alu_result,
    input  logic             alu_carry,
    input  logic             alu_overflow,
    input  logic             p_load,
    input  logic [7:0]       p_load_data,
    alu_writeback_if.master  mem,
    output logic [7:0]       reg_a,
    output logic [7:0]       reg_x,
    output logic [7:0]       reg_y,
    output logic [7:0]       status_p,
    output logic             carry_to_alu,
    output logic             busy,
    output logic             issue_err
);

    wb_state_e  state;
    alu_op_e    op_q;
    logic [1:0] dest_q;
    logic [3:0] mask_q;
    logic       req_q;
    logic [7:0] data_q;

    logic       commit;
    logic       to_mem;
    logic       wr_a;
    logic       wr_x;
    logic       wr_y;
    logic [3:0] mask_eff;
    logic [7:0] p_next;

    assign commit   = (state == S_WAIT);
    assign to_mem   = (dest_q == DEST_MEM);
    assign wr_a     = commit && !to_mem && (dest_q == DEST_A);
    assign wr_x     = commit && !to_mem && (dest_q == DEST_X);
    assign wr_y     = commit && !to_mem && (dest_q == DEST_Y);
    assign mask_eff = commit ? mask_q : 4'b0000;

    assign issue_err       = issue & busy;
    assign carry_to_alu    = status_p[FLAG_C];
    assign mem.mem_wr_req  = req_q;
    assign mem.mem_wr_data = data_q;

    status_merge u_merge (
        .p_old       (status_p),
        .result      (alu_result),
        .carry       (alu_carry),
        .overflow    (alu_overflow),
        .mask        (mask_eff),
        .p_load      (p_load),
        .p_load_data (p_load_data),
        .p_new       (p_next)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            op_q     <= OP_ADD;
            dest_q   <= 2'd0;
            mask_q   <= 4'd0;
            req_q    <= 1'b0;
            data_q   <= 8'h00;
            busy     <= 1'b0;
            reg_a    <= 8'h00;
            reg_x    <= 8'h00;
            reg_y    <= 8'h00;
            status_p <= p_fix(P_RESET);
        end else begin
            status_p <= p_next;
            if (wr_a) reg_a <= alu_result;
            if (wr_x) reg_x <= alu_result;
            if (wr_y) reg_y <= alu_result;
            unique case (state)
                S_IDLE: begin
                    if (issue) begin
                        op_q   <= alu_op_e'(issue_op);
                        dest_q <= issue_dest;
                        mask_q <= issue_mask;
                        busy   <= 1'b1;
                        state  <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (to_mem) begin
                        req_q  <= 1'b1;
                        data_q <= alu_result;
                        state  <= S_MEMWR;
                    end else begin
                        busy  <= 1'b0;
                        state <= S_IDLE;
                    end
                end
                S_MEMWR: begin
                    if (mem.mem_wr_ack) begin
                        req_q <= 1'b0;
                        busy  <= 1'b0;
                        state <= S_IDLE;
                    end
                end
                default: begin
                    req_q <= 1'b0;
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
            endcase
        end
    end

    // The ALU only defines ops up to LD.
    a_op_range: assert property (
        @(posedge clk) disable iff (!rst_n) busy |-> (op_q <= OP_LD)
    );

endmodule
